// File: rtl/nvram_upload.sv
`default_nettype none
// ============================================================================
//  Module      : nvram_upload
//  Description : Battery-backed CMOS store for the williams2 core. The CPU
//                reads and writes it on port A. hps_io's ioctl bus uses port B
//                to restore it on download and to read it back on upload. A
//                small FSM raises ioctl_upload_req after the CPU has been
//                quiet for a while, or on a manual save request.
//  Revision    : 1.0  initial release
// ============================================================================
module nvram_upload #(
  parameter int          ADDR_W      = 10,
  parameter int          DATA_W      = 4,
  parameter logic [7:0]  NV_INDEX    = 8'd4,
  parameter logic [23:0] IDLE_CYCLES = 24'd12_000_000
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              ioctl_download,
  input  logic              ioctl_upload,
  input  logic [7:0]        ioctl_index,
  input  logic [16:0]       ioctl_addr,
  input  logic              ioctl_wr,
  input  logic [7:0]        ioctl_dout,
  output logic [7:0]        ioctl_din,
  output logic              ioctl_wait,
  output logic              ioctl_upload_req,
  input  logic [ADDR_W-1:0] cpu_cmos_addr,
  input  logic              cpu_cmos_we,
  input  logic [DATA_W-1:0] cpu_cmos_di,
  output logic [DATA_W-1:0] cpu_cmos_do,
  input  logic              autosave_en,
  input  logic              save_trigger,
  output logic              dirty
);

  localparam int DEPTH = 1 << ADDR_W;

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_COUNT      = 3'd1;
  localparam logic [2:0] S_REQ        = 3'd2;
  localparam logic [2:0] S_WAIT_GRANT = 3'd3;
  localparam logic [2:0] S_UPLOAD     = 3'd4;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [2:0]  r_state;
  logic [23:0] r_counter;
  logic        r_shadow;
  logic        r_sel_dl_d;
  logic        r_sel_ul_d;
  logic        r_save_d;
  logic [16:0] r_prev_addr;

  logic              w_sel_dl;
  logic              w_sel_ul;
  logic              w_dl_fall;
  logic              w_ul_rise;
  logic              w_ul_fall;
  logic              w_save_rise;
  logic              w_b_in_range;
  logic [ADDR_W-1:0] w_b_addr;
  logic              w_b_we;
  logic              w_shadow_next;
  logic              w_cnt_zero;

  assign w_sel_dl      = ioctl_download & (ioctl_index == NV_INDEX);
  assign w_sel_ul      = ioctl_upload & (ioctl_index == NV_INDEX);
  assign w_dl_fall     = r_sel_dl_d & ~w_sel_dl;
  assign w_ul_rise     = w_sel_ul & ~r_sel_ul_d;
  assign w_ul_fall     = r_sel_ul_d & ~w_sel_ul;
  assign w_save_rise   = save_trigger & ~r_save_d;
  // Only the low ADDR_W bits of the byte address map onto the CMOS.
  assign w_b_in_range  = (ioctl_addr[16:ADDR_W] == '0);
  assign w_b_addr      = ioctl_addr[ADDR_W-1:0];
  assign w_b_we        = w_sel_dl & ioctl_wr & w_b_in_range;
  // A CPU write landing in the same cycle as the end of upload still counts.
  assign w_shadow_next = r_shadow | cpu_cmos_we;
  assign w_cnt_zero    = (r_counter == '0);

  // The HPS is stalled for one cycle whenever it presents a new address,
  // including the first cycle of an upload, while port B fetches the data.
  assign ioctl_wait       = w_sel_ul & (~r_sel_ul_d | (ioctl_addr != r_prev_addr));
  assign ioctl_upload_req = (r_state == S_REQ) & ~ioctl_download & ~ioctl_upload;

  // Upper download data bits are not stored in the nibble RAM.
  generate
    if (DATA_W < 8) begin : g_dout_unused
      logic w_unused_dout;
      assign w_unused_dout = ^ioctl_dout[7:DATA_W];
    end
  endgenerate

  // RAM write ports; port B is written last so it wins a same-address clash.
  always_ff @(posedge clk_sys) begin
    if (cpu_cmos_we) mem[cpu_cmos_addr] <= cpu_cmos_di;
    if (w_b_we)      mem[w_b_addr]      <= ioctl_dout[DATA_W-1:0];
  end

  // Port A registered read, returns the old contents on a write cycle.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) cpu_cmos_do <= '0;
    else       cpu_cmos_do <= mem[cpu_cmos_addr];
  end

  // Port B upload read; out-of-range addresses read back as erased bytes.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      ioctl_din <= 8'h00;
    end else if (w_sel_ul) begin
      ioctl_din <= w_b_in_range ? {{(8-DATA_W){1'b0}}, mem[w_b_addr]} : 8'hFF;
    end
  end

  // Edge-detect history for the selects, save button and upload address.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_sel_dl_d  <= 1'b0;
      r_sel_ul_d  <= 1'b0;
      r_save_d    <= 1'b0;
      r_prev_addr <= '0;
    end else begin
      r_sel_dl_d  <= w_sel_dl;
      r_sel_ul_d  <= w_sel_ul;
      r_save_d    <= save_trigger;
      r_prev_addr <= ioctl_addr;
    end
  end

  // Save scheduler: quiet-time counter, upload request and grant tracking.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_counter <= '0;
      r_shadow  <= 1'b0;
      dirty     <= 1'b0;
    end else if (w_dl_fall) begin
      // Restore finished: contents now match the file. A CPU write in this
      // very cycle happens after the restore, so it still marks dirty.
      r_state   <= S_IDLE;
      r_counter <= '0;
      dirty     <= cpu_cmos_we;
    end else begin
      if (cpu_cmos_we & ~w_sel_dl) dirty <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (w_save_rise) begin
            r_state <= S_REQ;
          end else if (cpu_cmos_we) begin
            r_counter <= IDLE_CYCLES;
            r_state   <= S_COUNT;
          end
        end
        S_COUNT: begin
          if (w_save_rise) begin
            r_state <= S_REQ;
          end else if (cpu_cmos_we) begin
            r_counter <= IDLE_CYCLES;
          end else if (w_cnt_zero) begin
            if (autosave_en) r_state <= S_REQ;
          end else begin
            r_counter <= r_counter - 24'd1;
          end
        end
        S_REQ: begin
          // The request is only issued while hps_io has no transfer open.
          if (~ioctl_download & ~ioctl_upload) begin
            r_counter <= IDLE_CYCLES;
            r_state   <= S_WAIT_GRANT;
          end
        end
        S_WAIT_GRANT: begin
          if (w_ul_rise) begin
            r_shadow <= 1'b0;
            r_state  <= S_UPLOAD;
          end else if (w_save_rise) begin
            r_state <= S_REQ;
          end else if (w_cnt_zero) begin
            // Grant never came; COUNT at zero re-requests if autosave is on.
            r_state <= S_COUNT;
          end else begin
            r_counter <= r_counter - 24'd1;
          end
        end
        S_UPLOAD: begin
          if (w_ul_fall) begin
            dirty <= w_shadow_next;
            if (w_shadow_next) begin
              r_counter <= IDLE_CYCLES;
              r_state   <= S_COUNT;
            end else begin
              r_state <= S_IDLE;
            end
          end else if (cpu_cmos_we) begin
            r_shadow <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
